// File: rtl/alu_rr_arbiter.sv
// alu_rr_arbiter
//    Shares one W-bit ALU (AND/OR/XOR/ADD) between two requesters using
//    round-robin arbitration. An accepted operation is computed and stored in
//    a single tagged response slot, which has its own valid/ready handshake.
//    Per-requester counters record how many operations each one had accepted.
//
// Ports
//    clk_i, reset_i             clock, synchronous active-high reset
//    reqN_valid_i/reqN_ready_o  request handshake, N = 0/1
//    reqN_a_i, reqN_b_i         operands
//    reqN_op_i                  00 AND, 01 OR, 10 XOR, 11 ADD (truncated)
//    rsp_valid_o/rsp_ready_i    response slot handshake
//    rsp_id_o, rsp_ans_o        requester tag and ALU result
//    cnt0_o, cnt1_o             accepted-op counters (wrap)
//
// State | meaning
// ------+-------------------------------------------
// EMPTY | response slot holds nothing (rsp_valid=0)
// FULL  | response slot holds a result (rsp_valid=1)
module alu_rr_arbiter #(
   parameter int W     = 4,
   parameter int CNT_W = 8
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             req0_valid_i,
   output logic             req0_ready_o,
   input  logic [W-1:0]     req0_a_i,
   input  logic [W-1:0]     req0_b_i,
   input  logic [1:0]       req0_op_i,
   input  logic             req1_valid_i,
   output logic             req1_ready_o,
   input  logic [W-1:0]     req1_a_i,
   input  logic [W-1:0]     req1_b_i,
   input  logic [1:0]       req1_op_i,
   output logic             rsp_valid_o,
   input  logic             rsp_ready_i,
   output logic             rsp_id_o,
   output logic [W-1:0]     rsp_ans_o,
   output logic [CNT_W-1:0] cnt0_o,
   output logic [CNT_W-1:0] cnt1_o
);

   typedef enum logic {S_EMPTY = 1'b0, S_FULL = 1'b1} state_e;

   state_e             state_q, state_d;
   logic               prio_q, prio_d;
   logic               id_q, id_d;
   logic [W-1:0]       ans_q, ans_d;
   logic [CNT_W-1:0]   cnt0_q, cnt0_d;
   logic [CNT_W-1:0]   cnt1_q, cnt1_d;

   logic               slot_free;
   logic               grant0, grant1;
   logic               acc0, acc1;

   function automatic logic [W-1:0] alu(input logic [W-1:0] a,
                                        input logic [W-1:0] b,
                                        input logic [1:0]   op);
      logic [W-1:0] r;
      case (op)
         2'b00:   r = a & b;
         2'b01:   r = a | b;
         2'b10:   r = a ^ b;
         default: r = a + b;
      endcase
      return r;
   endfunction

   // Grant depends only on valids and the priority pointer, never on operands.
   assign slot_free = (state_q == S_EMPTY) || rsp_ready_i;
   assign grant1    = req1_valid_i && (!req0_valid_i || prio_q);
   assign grant0    = req0_valid_i && !grant1;

   // Reset wins over everything, so nothing is offered while it is asserted.
   assign acc0 = !reset_i && slot_free && grant0;
   assign acc1 = !reset_i && slot_free && grant1;

   assign req0_ready_o = acc0;
   assign req1_ready_o = acc1;

   always_comb begin
      state_d = state_q;
      prio_d  = prio_q;
      id_d    = id_q;
      ans_d   = ans_q;
      cnt0_d  = cnt0_q;
      cnt1_d  = cnt1_q;
      if (acc0) begin
         state_d = S_FULL;
         ans_d   = alu(req0_a_i, req0_b_i, req0_op_i);
         id_d    = 1'b0;
         prio_d  = 1'b1;
         cnt0_d  = cnt0_q + CNT_W'(1);
      end else if (acc1) begin
         state_d = S_FULL;
         ans_d   = alu(req1_a_i, req1_b_i, req1_op_i);
         id_d    = 1'b1;
         prio_d  = 1'b0;
         cnt1_d  = cnt1_q + CNT_W'(1);
      end else if (rsp_ready_i) begin
         // Retire without replacement; tag and data keep their last values.
         state_d = S_EMPTY;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= S_EMPTY;
         prio_q  <= 1'b0;
         id_q    <= 1'b0;
         ans_q   <= '0;
         cnt0_q  <= '0;
         cnt1_q  <= '0;
      end else begin
         state_q <= state_d;
         prio_q  <= prio_d;
         id_q    <= id_d;
         ans_q   <= ans_d;
         cnt0_q  <= cnt0_d;
         cnt1_q  <= cnt1_d;
      end
   end

   assign rsp_valid_o = (state_q == S_FULL);
   assign rsp_id_o    = id_q;
   assign rsp_ans_o   = ans_q;
   assign cnt0_o      = cnt0_q;
   assign cnt1_o      = cnt1_q;

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Testbench for alu_rr_arbiter: directed scenarios with literal expectations,
// then randomized traffic, all checked every cycle against a rule-level model.
// A second instance with 2-bit counters shares the same inputs so counter
// wrap can be observed.
module tb_alu_rr_arbiter;
   localparam int W = 4;

   logic         clk_i = 1'b0;
   logic         reset_i;
   logic         req0_valid_i, req1_valid_i, rsp_ready_i;
   logic [W-1:0] req0_a_i, req0_b_i, req1_a_i, req1_b_i;
   logic [1:0]   req0_op_i, req1_op_i;

   logic         req0_ready_o, req1_ready_o, rsp_valid_o, rsp_id_o;
   logic [W-1:0] rsp_ans_o;
   logic [7:0]   cnt0_o, cnt1_o;

   logic         w2_req0_ready, w2_req1_ready, w2_rsp_valid, w2_rsp_id;
   logic [W-1:0] w2_rsp_ans;
   logic [1:0]   w2_cnt0, w2_cnt1;

   int total = 0;
   int bad   = 0;

   alu_rr_arbiter #(.W(W), .CNT_W(8)) dut (
      .clk_i(clk_i), .reset_i(reset_i),
      .req0_valid_i(req0_valid_i), .req0_ready_o(req0_ready_o),
      .req0_a_i(req0_a_i), .req0_b_i(req0_b_i), .req0_op_i(req0_op_i),
      .req1_valid_i(req1_valid_i), .req1_ready_o(req1_ready_o),
      .req1_a_i(req1_a_i), .req1_b_i(req1_b_i), .req1_op_i(req1_op_i),
      .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
      .rsp_id_o(rsp_id_o), .rsp_ans_o(rsp_ans_o),
      .cnt0_o(cnt0_o), .cnt1_o(cnt1_o));

   alu_rr_arbiter #(.W(W), .CNT_W(2)) dut_w2 (
      .clk_i(clk_i), .reset_i(reset_i),
      .req0_valid_i(req0_valid_i), .req0_ready_o(w2_req0_ready),
      .req0_a_i(req0_a_i), .req0_b_i(req0_b_i), .req0_op_i(req0_op_i),
      .req1_valid_i(req1_valid_i), .req1_ready_o(w2_req1_ready),
      .req1_a_i(req1_a_i), .req1_b_i(req1_b_i), .req1_op_i(req1_op_i),
      .rsp_valid_o(w2_rsp_valid), .rsp_ready_i(rsp_ready_i),
      .rsp_id_o(w2_rsp_id), .rsp_ans_o(w2_rsp_ans),
      .cnt0_o(w2_cnt0), .cnt1_o(w2_cnt1));

   always #5 clk_i = ~clk_i;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   bit armed = 0;
   int m_valid, m_id, m_ans, m_prio, m_cnt0, m_cnt1;

   function automatic int alu_ref(input int a, input int b, input int op);
      case (op)
         0:       return a & b;
         1:       return a | b;
         2:       return a ^ b;
         default: return (a + b) % 16;
      endcase
   endfunction

   // Which requester the block should take this cycle: -1 for none.
   function automatic int who_wins();
      if (reset_i) return -1;
      if (m_valid == 1 && !rsp_ready_i) return -1;
      if (req0_valid_i && req1_valid_i) return m_prio;
      if (req0_valid_i) return 0;
      if (req1_valid_i) return 1;
      return -1;
   endfunction

   always @(posedge clk_i) begin
      int w;
      w = who_wins();
      if (reset_i) begin
         armed  = 1;
         m_valid = 0; m_id = 0; m_ans = 0; m_prio = 0; m_cnt0 = 0; m_cnt1 = 0;
      end else if (w == 0) begin
         m_ans = alu_ref(int'(req0_a_i), int'(req0_b_i), int'(req0_op_i));
         m_id = 0; m_valid = 1; m_prio = 1; m_cnt0++;
      end else if (w == 1) begin
         m_ans = alu_ref(int'(req1_a_i), int'(req1_b_i), int'(req1_op_i));
         m_id = 1; m_valid = 1; m_prio = 0; m_cnt1++;
      end else if (rsp_ready_i) begin
         m_valid = 0;
      end
   end

   always @(negedge clk_i) begin
      int w;
      if (armed) begin
         w = who_wins();
         chk("req0_ready", int'(req0_ready_o), int'(w == 0));
         chk("req1_ready", int'(req1_ready_o), int'(w == 1));
         chk("rsp_valid", int'(rsp_valid_o), m_valid);
         chk("rsp_id", int'(rsp_id_o), m_id);
         chk("rsp_ans", int'(rsp_ans_o), m_ans);
         chk("cnt0", int'(cnt0_o), m_cnt0 % 256);
         chk("cnt1", int'(cnt1_o), m_cnt1 % 256);
         chk("w2_cnt0", int'(w2_cnt0), m_cnt0 % 4);
         chk("w2_cnt1", int'(w2_cnt1), m_cnt1 % 4);
      end
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic idle();
      req0_valid_i = 0; req1_valid_i = 0;
   endtask

   task automatic set0(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op);
      req0_valid_i = 1; req0_a_i = a; req0_b_i = b; req0_op_i = op;
   endtask

   task automatic set1(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op);
      req1_valid_i = 1; req1_a_i = a; req1_b_i = b; req1_op_i = op;
   endtask

   task automatic pulse_reset();
      step(); reset_i = 1; idle();
      step(); reset_i = 0;
   endtask

   initial begin
      bit h0, h1;
      reset_i = 1; rsp_ready_i = 1; idle();
      req0_a_i = 0; req0_b_i = 0; req0_op_i = 0;
      req1_a_i = 0; req1_b_i = 0; req1_op_i = 0;
      repeat (2) step();
      reset_i = 0;

      // reset values and single ADD from req0
      @(negedge clk_i);
      chk("pin_reset_valid", int'(rsp_valid_o), 0);
      chk("pin_reset_cnt0", int'(cnt0_o), 0);
      step();
      set0(4'h5, 4'h3, 2'b11);
      @(negedge clk_i);
      chk("pin_s1_ready0", int'(req0_ready_o), 1);
      step(); idle();
      @(negedge clk_i);
      chk("pin_s1_valid", int'(rsp_valid_o), 1);
      chk("pin_s1_id", int'(rsp_id_o), 0);
      chk("pin_s1_ans", int'(rsp_ans_o), 8);
      chk("pin_s1_cnt0", int'(cnt0_o), 1);

      // alternating grants under a permanent tie
      pulse_reset();
      set0(4'hC, 4'hA, 2'b00);
      set1(4'hC, 4'hA, 2'b10);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk_i);
         chk("pin_rr_ready0", int'(req0_ready_o), int'(k % 2 == 0));
         chk("pin_rr_ready1", int'(req1_ready_o), int'(k % 2 == 1));
         if (k > 0) chk("pin_rr_ans", int'(rsp_ans_o), (k % 2 == 1) ? 8 : 6);
         step();
      end
      idle();
      @(negedge clk_i);
      chk("pin_rr_ans_last", int'(rsp_ans_o), 6);
      chk("pin_rr_cnt0", int'(cnt0_o), 2);
      chk("pin_rr_cnt1", int'(cnt1_o), 2);

      // backpressure
      step();
      set1(4'h9, 4'h4, 2'b01);
      @(negedge clk_i);
      chk("pin_bp_ready1", int'(req1_ready_o), 1);
      step();
      idle(); rsp_ready_i = 0;
      set0(4'h3, 4'h5, 2'b10);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk_i);
         chk("pin_bp_valid", int'(rsp_valid_o), 1);
         chk("pin_bp_ans", int'(rsp_ans_o), 13);
         chk("pin_bp_id", int'(rsp_id_o), 1);
         chk("pin_bp_ready0", int'(req0_ready_o), 0);
         step();
      end
      rsp_ready_i = 1;
      @(negedge clk_i);
      chk("pin_bp_release", int'(req0_ready_o), 1);
      step();
      idle();
      set0(4'hF, 4'h2, 2'b11);
      @(negedge clk_i);
      chk("pin_bp_ans_after", int'(rsp_ans_o), 6);
      chk("pin_bp_id_after", int'(rsp_id_o), 0);
      step(); idle();
      @(negedge clk_i);
      chk("pin_add_wrap", int'(rsp_ans_o), 1);

      // counter wrap on the 2-bit instance
      pulse_reset();
      set0(4'h1, 4'h1, 2'b00);
      repeat (5) step();
      idle();
      @(negedge clk_i);
      chk("pin_wrap_w2_cnt0", int'(w2_cnt0), 1);
      chk("pin_wrap_cnt0", int'(cnt0_o), 5);

      // reset while the slot is full and both requesters wait
      step();
      rsp_ready_i = 0;
      set0(4'h2, 4'h2, 2'b01);
      set1(4'h7, 4'h1, 2'b00);
      step();
      reset_i = 1;
      @(negedge clk_i);
      chk("pin_rst_ready0", int'(req0_ready_o), 0);
      chk("pin_rst_ready1", int'(req1_ready_o), 0);
      step();
      reset_i = 0;
      @(negedge clk_i);
      chk("pin_rst_valid", int'(rsp_valid_o), 0);
      chk("pin_rst_cnt0", int'(cnt0_o), 0);
      chk("pin_rst_cnt1", int'(cnt1_o), 0);
      chk("pin_rst_tie", int'(req0_ready_o), 1);

      // randomized traffic, operands held stable while waiting
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk_i);
         h0 = req0_valid_i && !req0_ready_o;
         h1 = req1_valid_i && !req1_ready_o;
         step();
         reset_i = ($urandom_range(0, 99) == 0);
         rsp_ready_i = ($urandom_range(0, 3) != 0);
         if (!h0) begin
            req0_valid_i = ($urandom_range(0, 2) != 0);
            req0_a_i = 4'($urandom); req0_b_i = 4'($urandom); req0_op_i = 2'($urandom);
         end
         if (!h1) begin
            req1_valid_i = ($urandom_range(0, 2) != 0);
            req1_a_i = 4'($urandom); req1_b_i = 4'($urandom); req1_op_i = 2'($urandom);
         end
      end
      step(); reset_i = 0; idle();
      @(negedge clk_i);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/alu_rr_arbiter.md
Name: alu_rr_arbiter

Overview:
- Shares one W-bit ALU between two requesters (req0, req1) using round-robin arbitration.
- The ALU implements four ops: op 00 AND, 01 OR, 10 XOR, 11 ADD. ADD is truncated to W bits with no carry out.
- Each request uses a valid/ready handshake. The block computes the result and registers it into a single tagged response slot, which has its own valid/ready handshake.
- Sits between the issue logic and the writeback/consumer. It also keeps per-requester service counters for debug and perf readout.

Parameters:
- W, 4, operand and result width.
- CNT_W, 8, width of each per-requester serviced counter (wraps).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- req0_valid  input  1  requester 0 presents an operation.
- req0_ready  output  1  requester 0 operation accepted this cycle.
- req0_a  input  W  operand A, requester 0.
- req0_b  input  W  operand B, requester 0.
- req0_op  input  2  opcode, requester 0.
- req1_valid, req1_ready, req1_a, req1_b, req1_op  same as above, requester 1.
- rsp_valid  output  1  response slot holds a result.
- rsp_ready  input  1  consumer takes the response this cycle.
- rsp_id  output  1  requester the result belongs to (0/1).
- rsp_ans  output  W  ALU result.
- cnt0  output  CNT_W  number of accepted req0 operations.
- cnt1  output  CNT_W  number of accepted req1 operations.

Behaviour:
- Reset (synchronous, active-high, sampled at the clk edge):
  - rsp_valid=0, rsp_id=0, rsp_ans=0, cnt0=0, cnt1=0.
  - Priority pointer prio=0, so req0 wins the first tie.
  - Reset overrides every other event in the same cycle. An in-flight response is discarded and nothing is accepted in the reset cycle.
- Slot free:
  - slot_free = !rsp_valid || rsp_ready. This allows back-to-back throughput of 1 op/cycle.
- Grant (combinational):
  - Only req0_valid is high → grant 0.
  - Only req1_valid is high → grant 1.
  - Both are high → grant prio.
  - Neither is high → no grant.
- Ready:
  - reqN_ready = slot_free && grant==N && reqN_valid.
  - At most one ready is high per cycle.
  - ready must not depend on reqN_a/b/op.
- Accept (reqN_valid && reqN_ready) at edge:
  - rsp_ans <= ALU(reqN_a, reqN_b, reqN_op).
  - rsp_id <= N.
  - rsp_valid <= 1.
  - prio <= ~N.
  - cntN <= cntN+1, wrapping from 2^CNT_W-1 to 0.
- Latency: the result appears on rsp_* the cycle after acceptance, exactly 1 cycle.
- No accept while rsp_ready:
  - rsp_valid <= 0.
  - rsp_ans and rsp_id hold their last values.
- Hold: while rsp_valid && !rsp_ready, the slot is full. rsp_valid, rsp_id and rsp_ans stay stable and both readies are 0.
- Simultaneous rsp_ready and a new accept: the old response retires and the new one loads in the same edge, so rsp_valid stays 1.
- prio changes only on an accept. A requester that is refused because the slot is full keeps its turn.
- A single requester that is continuously valid gets every free slot. Round-robin matters only when both are valid.
- Requesters must hold operands stable while valid && !ready. The block latches operands only on accept.
- State machine, encoded by rsp_valid:
  - EMPTY → FULL on accept.
  - FULL → EMPTY on rsp_ready with no accept.
  - FULL → FULL on accept with rsp_ready, or when stalled.

Test Plan:
- Reset, then req0 only (a=4'h5, b=4'h3, op=11) → req0_ready=1 in cycle 0; next cycle rsp_valid=1, rsp_id=0, rsp_ans=4'h8, cnt0=1.
- Both valid every cycle with rsp_ready=1 (req0: 4'hC AND 4'hA; req1: 4'hC XOR 4'hA) → grants alternate 0,1,0,1; rsp_ans alternates 4'h8, 4'h6; after 4 accepts cnt0=cnt1=2.
- Backpressure: hold rsp_ready=0 for 3 cycles after one accept (req1 0x9 OR 0x4) → rsp_ans stays 4'hD with rsp_id=1; both readies stay 0; req0 pending since the first stall cycle is granted first when rsp_ready rises.
- ADD wrap: a=4'hF, b=4'h2, op=11 → rsp_ans=4'h1.
- Counter wrap: with CNT_W=2, perform 5 req0 accepts → cnt0=1.
- Reset mid-operation: rsp_valid=1 with both requests valid, assert reset for 1 cycle → next cycle rsp_valid=0, counters 0, no readies during reset; first post-reset tie is granted to req0.
